// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed multiplier: default operand
// width, the number of shift-add iterations and the control state type.
package mult_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        HOLD
    } mult_state_t;

endpackage

// File: rtl/mult_sign_mag.sv
// Sign/magnitude splitter for the multiplier operands. The product sign is
// the XOR of the operand signs; each magnitude is the unsigned absolute value,
// so the most negative operand maps to 2^(WIDTH-1) without overflow.
module mult_sign_mag #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             sign_result,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b
);

    // Product sign and unsigned absolute values of both operands
    always_comb begin
        sign_result = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        mag_a       = op_a[WIDTH-1] ? (-op_a) : op_a;
        mag_b       = op_b[WIDTH-1] ? (-op_b) : op_b;
    end

endmodule

// File: rtl/mult.sv
// Sequential signed multiplier. Multiplies operand magnitudes with a
// shift-add loop (one multiplier bit per clock), then applies the sign to
// the 2*WIDTH-bit accumulator and writes it to the HI/LO pair.
// Optional build macro MULT_EARLY_TERM_EN: leave the loop as soon as the
// remaining multiplier bits are all zero (same results, shorter latency).
module mult
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] RegAOut,
    input  logic [WIDTH-1:0] RegBOut,
    input  logic             MultCtrl,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             MultDone
);

    localparam int CNT_W = $clog2(ITER_COUNT);

    logic               sign_result;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;

    mult_state_t        state_q,  state_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               flag_q,   flag_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;
    logic               done_q,   done_d;
    logic               last_iter;

    mult_sign_mag #(
        .WIDTH (WIDTH)
    ) u_sign_mag (
        .op_a        (RegAOut),
        .op_b        (RegBOut),
        .sign_result (sign_result),
        .mag_a       (multiplicand),
        .mag_b       (multiplier)
    );

    // Next-state and datapath: latch on start, shift-add in RUN, publish in DONE
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        flag_d    = flag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        last_iter = 1'b0;

        case (state_q)
            IDLE: begin
                if (MultCtrl) begin
                    mcand_d  = {{WIDTH{1'b0}}, multiplicand};
                    mplier_d = multiplier;
                    flag_d   = sign_result;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + CNT_W'(1);
                last_iter = (cnt_q == CNT_W'(ITER_COUNT - 1));
`ifdef MULT_EARLY_TERM_EN
                last_iter = last_iter || (mplier_d == '0);
`endif
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                {hi_d, lo_d} = flag_q ? (-acc_q) : acc_q;
                done_d       = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (!MultCtrl) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs; reset aborts any run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign MultDone = done_q;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for the sequential signed multiplier. Each start pushes
// the arithmetically expected product and latency into a scoreboard; an
// independent monitor pops and compares whenever MultDone is seen.
module tb_mult;

    logic        clk;
    logic        reset;
    logic [31:0] RegAOut;
    logic [31:0] RegBOut;
    logic        MultCtrl;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        MultDone;

    typedef struct {
        logic [63:0] prod;
        int          startEdge;
        int          latency;
    } expT;

    expT sb[$];
    int  checks    = 0;
    int  failures  = 0;
    int  edgeCount = 0;
    int  doneCount = 0;

    mult dut (
        .clk      (clk),
        .reset    (reset),
        .RegAOut  (RegAOut),
        .RegBOut  (RegBOut),
        .MultCtrl (MultCtrl),
        .HI       (HI),
        .LO       (LO),
        .MultDone (MultDone)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to measure start-to-done latency
    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Hard stop in case something wedges the run entirely
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference product: plain signed 64-bit arithmetic
    function automatic logic [63:0] refProd(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Expected edges from start to MultDone
    function automatic int expLatency(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] m;
        int n;
        m = b[31] ? (32'd0 - b) : b;
        n = 1;
        while (n < 32 && (m >> n) != 32'd0) n++;
        return n + 1;
`else
        return 33;
`endif
    endfunction

    // One comparison: counts it and reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: on every MultDone pop the scoreboard and compare result/latency
    initial begin
        logic prevDone;
        expT  e;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            if (MultDone === 1'b1) begin
                doneCount++;
                checkOutput("done_width", 64'(prevDone), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got MultDone=1 at edge %0d expected no pulse", edgeCount);
                end else begin
                    e = sb.pop_front();
                    checkOutput("product", {HI, LO}, e.prod);
                    checkOutput("latency", 64'(edgeCount - e.startEdge), 64'(e.latency));
                end
            end
            prevDone = MultDone;
        end
    end

    // Start one multiply, scramble operands after the start edge, wait for done
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit hold);
        expT e;
        @(negedge clk);
        RegAOut  = a;
        RegBOut  = b;
        MultCtrl = 1'b1;
        e.prod      = refProd(a, b);
        e.startEdge = edgeCount + 1;
        e.latency   = expLatency(b);
        sb.push_back(e);
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) begin
                RegAOut = $urandom;
                RegBOut = $urandom;
            end
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout: got no MultDone for %0h*%0h expected one within 60 cycles", a, b);
            sb.delete();
        end
        if (!hold) MultCtrl = 1'b0;
    endtask

    // Main sequence: reset, directed cases, hold, reset abort, random cases
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int savedCount;

        reset    = 1'b1;
        RegAOut  = '0;
        RegBOut  = '0;
        MultCtrl = 1'b0;
        #12;
        checkOutput("reset_hi", 64'(HI), 64'd0);
        checkOutput("reset_lo", 64'(LO), 64'd0);
        checkOutput("reset_done", 64'(MultDone), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        RegAOut = 32'hFFFF_FFFB;
        RegBOut = 32'd3;
        #1;
        checkOutput("sign_result", 64'(dut.sign_result), 64'd1);
        checkOutput("multiplicand", 64'(dut.multiplicand), 64'd5);
        checkOutput("multiplier", 64'(dut.multiplier), 64'd3);

        applyStimulus(32'hFFFF_FFFB, 32'd3, 1'b0);
        checkOutput("neg5x3_hi", 64'(HI), 64'hFFFF_FFFF);
        checkOutput("neg5x3_lo", 64'(LO), 64'hFFFF_FFF1);
        applyStimulus(32'd7, 32'd6, 1'b0);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0);
        checkOutput("minxmin_hi", 64'(HI), 64'h4000_0000);
        applyStimulus(32'h8000_0000, 32'd1, 1'b0);
        applyStimulus(32'd123, 32'd0, 1'b0);
        applyStimulus(32'd9, 32'hFFFF_FFFE, 1'b0);
        checkOutput("9xneg2_lo", 64'(LO), 64'hFFFF_FFEE);

        applyStimulus(32'd7, 32'd6, 1'b1);
        savedCount = doneCount;
        repeat (50) @(negedge clk);
        checkOutput("hold_no_restart", 64'(doneCount), 64'(savedCount));
        MultCtrl = 1'b0;
        applyStimulus(32'hFFFF_FFFB, 32'd3, 1'b0);

        @(negedge clk);
        RegAOut  = 32'h1234_5678;
        RegBOut  = 32'h7FFF_FFFF;
        MultCtrl = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        reset    = 1'b1;
        MultCtrl = 1'b0;
        #1;
        checkOutput("abort_hi", 64'(HI), 64'd0);
        checkOutput("abort_lo", 64'(LO), 64'd0);
        checkOutput("abort_done", 64'(MultDone), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("abort_no_result", {HI, LO}, 64'd0);
        applyStimulus(32'h1234_5678, 32'h7FFF_FFFF, 1'b0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = 32'd0 - 32'($urandom_range(1, 300));
                default: rb = $urandom;
            endcase
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
            if (MultCtrl) begin
                repeat (3) @(negedge clk);
                MultCtrl = 1'b0;
            end
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult.md
Name: mult

Overview:
- Sequential signed (two's-complement) 32x32 multiplier for the datapath; result goes to the HI/LO register pair.
- Works on magnitudes with a shift-add loop, one multiplier bit per clock, then applies the sign correction.
- Started by the control unit through MultCtrl; MultDone tells the control unit that HI/LO are valid.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH bits.
- Only 32 is required to be supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- RegAOut  input  WIDTH  multiplicand operand (signed).
- RegBOut  input  WIDTH  multiplier operand (signed).
- MultCtrl  input  1  start request, level-sensitive.
- HI  output  WIDTH  upper half of the signed product.
- LO  output  WIDTH  lower half of the signed product.
- MultDone  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - HI=0, LO=0, MultDone=0.
  - State returns to IDLE and all working registers clear.
  - Reset during an operation aborts it; no partial result reaches HI/LO.
- Combinational internal signals:
  - sign_result = RegAOut[31] ^ RegBOut[31].
  - multiplicand = |RegAOut|, multiplier = |RegBOut|, both as 32-bit unsigned values.
  - |0x80000000| = 0x80000000 (unsigned 2^31).
  - These signals must be observable hierarchically with exactly these names.
- States: IDLE, RUN, DONE, HOLD.
- IDLE:
  - If MultCtrl=1 at a rising edge, latch multiplicand into a 64-bit register, multiplier into a 32-bit shift register, and sign_result into a flag.
  - Clear the 64-bit accumulator and the counter, then go to RUN.
- RUN, 32 cycles:
  - Each cycle: if multiplier LSB=1, accumulator += multiplicand register.
  - Then shift the multiplicand register left by 1 and the multiplier register right by 1, and increment the counter.
  - After the 32nd iteration go to DONE.
- DONE, one cycle:
  - {HI,LO} = flag ? -(accumulator) : accumulator, using 64-bit two's-complement negation.
  - MultDone=1 for exactly this one cycle.
  - Then go to HOLD.
- HOLD:
  - Stay until MultCtrl=0, then go to IDLE.
  - This prevents an automatic restart while the controller keeps MultCtrl high.
- Latency: the start edge is edge 0; HI/LO update and MultDone rises at edge 33; MultDone falls at edge 34.
- HI/LO hold the last result until the next DONE or a reset.
- Operand changes after the start edge are ignored.
- MultCtrl is ignored in RUN and DONE.
- The result is exact for all inputs; -2^31 * -2^31 = 2^62 with no overflow.

Optional Feature:
- MULT_EARLY_TERM_EN defined:
  - RUN exits to DONE as soon as the shifted multiplier register is zero.
  - A multiplier of 0 therefore reaches DONE on the edge after the start edge.
  - Latency varies with the operand; results are identical.
- Not defined: fixed 33-edge latency exactly as described above.

Decomposition:
- Package mult_pkg holds:
  - WIDTH_DEF = 32.
  - ITER_COUNT = 32.
  - The state enum type mult_state_t {IDLE, RUN, DONE, HOLD}.
- One sub-module, mult_sign_mag: purely combinational; takes both operands and produces sign_result and both magnitudes.
- The FSM and datapath stay in mult.

Test Plan:
- -5*3 (0xFFFFFFFB, 3), MultCtrl held 1 -> before start: sign_result=1, multiplicand=5, multiplier=3. At MultDone: HI=0xFFFFFFFF (-1), LO=0xFFFFFFF1 (-15). MultDone rises exactly 33 edges after start.
- 7*6 -> HI=0, LO=42. -1*-1 (0xFFFFFFFF, 0xFFFFFFFF) -> HI=0, LO=1.
- 0x80000000*0x80000000 -> HI=0x40000000, LO=0. 0x80000000*1 -> HI=0xFFFFFFFF, LO=0x80000000.
- MultCtrl held high after done -> MultDone pulses exactly once and no second run occurs. Drop MultCtrl, raise it again -> a new result after 33 edges.
- Assert reset at edge 10 of a run -> HI=LO=0 and MultDone=0 immediately (asynchronous); a new start after reset gives the correct product.
- With MULT_EARLY_TERM_EN: 123*0 -> HI=LO=0 with MultDone at edge 2; 9*-2 -> HI=0xFFFFFFFF, LO=0xFFFFFFEE.
